// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: controller states,
// per-cycle output modes, counter widths and the load-use detector.
package hazard_ctrl_pkg;

  localparam int CNT_W  = 16;  // event counter width
  localparam int WAIT_W = 8;   // memory wait counter width

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_ERROR    = 2'd3
  } state_e;

  // What the pipeline-control outputs look like this cycle.
  typedef enum logic [1:0] {
    MODE_HOLD     = 2'd0,  // pipeline parked (IDLE / ERROR)
    MODE_MEMSTALL = 2'd1,  // whole pipe frozen waiting on data memory
    MODE_ACTIVE   = 2'd2   // normal flow, load-use stall or branch flush
  } mode_e;

  // A load in EX writes a register that the instruction in ID reads.
  function automatic logic load_use_hit(
    input logic       ex_memread,
    input logic [4:0] ex_rd,
    input logic [4:0] id_rs1,
    input logic [4:0] id_rs2
  );
    return ex_memread && (ex_rd != 5'd0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear, used for the event counters.
module sat_counter
  import hazard_ctrl_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear wins, otherwise count up and stick at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {W{1'b0}};
    end else if (en_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and
// data-memory wait stalls with a timeout that parks the pipe in ERROR.
// The stall/flush outputs are combinational so the pipeline reacts in the
// same cycle the hazard is seen.
// Build option: define HAZARD_CTRL_PERF_EN to implement the event counters;
// otherwise the counter ports read as zero and no counter flops exist.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16  // legal 1..255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [4:0]       id_rs1_addr_i,
  input  logic [4:0]       id_rs2_addr_i,
  input  logic [4:0]       ex_rd_addr_i,
  input  logic             ex_memread_i,
  input  logic             id_branch_taken_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic             if_id_flush_o,
  output logic             id_ex_bubble_o,
  output logic             pipe_stall_o,
  output logic             err_o,
  output logic [CNT_W-1:0] load_use_cnt_o,
  output logic [CNT_W-1:0] mem_wait_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam logic [WAIT_W-1:0] TIMEOUT_C = WAIT_W'(MEM_TIMEOUT);

  state_e            state_q;
  state_e            state_d;
  logic [WAIT_W-1:0] wait_q;
  logic [WAIT_W-1:0] wait_d;
  logic [WAIT_W-1:0] wait_inc_s;
  mode_e             mode_s;
  logic              hazard_s;

  logic pc_write_s;
  logic if_id_write_s;
  logic if_id_flush_s;
  logic id_ex_bubble_s;
  logic pipe_stall_s;

  assign hazard_s   = load_use_hit(ex_memread_i, ex_rd_addr_i, id_rs1_addr_i, id_rs2_addr_i);
  assign wait_inc_s = wait_q + {{(WAIT_W-1){1'b0}}, 1'b1};

  // Next state, wait counter and output mode. wait_q counts the ack-less
  // cycles spent in MEM_WAIT; the one reaching MEM_TIMEOUT trips ERROR.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    mode_s  = MODE_HOLD;
    case (state_q)
      ST_IDLE: begin
        mode_s = MODE_HOLD;
        wait_d = {WAIT_W{1'b0}};
        if (start_i) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (mem_req_i && !mem_ack_i) begin
          mode_s  = MODE_MEMSTALL;
          state_d = ST_MEM_WAIT;
          wait_d  = {WAIT_W{1'b0}};
        end else begin
          mode_s  = MODE_ACTIVE;
          state_d = ST_RUN;
        end
      end
      ST_MEM_WAIT: begin
        if (!mem_ack_i) begin
          mode_s = MODE_MEMSTALL;
          wait_d = wait_inc_s;
          if (wait_inc_s == TIMEOUT_C) begin
            state_d = ST_ERROR;
          end else begin
            state_d = ST_MEM_WAIT;
          end
        end else begin
          // Ack releases the stall this very cycle; normal RUN rules apply.
          mode_s  = MODE_ACTIVE;
          state_d = ST_RUN;
          wait_d  = {WAIT_W{1'b0}};
        end
      end
      ST_ERROR: begin
        mode_s  = MODE_HOLD;
        state_d = ST_ERROR;
      end
      default: begin
        mode_s  = MODE_HOLD;
        state_d = ST_IDLE;
        wait_d  = {WAIT_W{1'b0}};
      end
    endcase
  end

  // Pipeline control from the mode; load-use beats branch flush.
  always_comb begin
    pc_write_s     = 1'b0;
    if_id_write_s  = 1'b0;
    if_id_flush_s  = 1'b0;
    id_ex_bubble_s = 1'b1;
    pipe_stall_s   = 1'b1;
    case (mode_s)
      MODE_MEMSTALL: begin
        id_ex_bubble_s = 1'b0;
        pipe_stall_s   = 1'b1;
      end
      MODE_ACTIVE: begin
        pipe_stall_s = 1'b0;
        if (hazard_s) begin
          id_ex_bubble_s = 1'b1;
        end else if (id_branch_taken_i) begin
          pc_write_s     = 1'b1;
          if_id_write_s  = 1'b1;
          if_id_flush_s  = 1'b1;
          id_ex_bubble_s = 1'b0;
        end else begin
          pc_write_s     = 1'b1;
          if_id_write_s  = 1'b1;
          id_ex_bubble_s = 1'b0;
        end
      end
      default: begin
        pc_write_s     = 1'b0;
        if_id_write_s  = 1'b0;
        if_id_flush_s  = 1'b0;
        id_ex_bubble_s = 1'b1;
        pipe_stall_s   = 1'b1;
      end
    endcase
  end

  // State and wait-counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      wait_q  <= {WAIT_W{1'b0}};
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  assign pc_write_o     = pc_write_s;
  assign if_id_write_o  = if_id_write_s;
  assign if_id_flush_o  = if_id_flush_s;
  assign id_ex_bubble_o = id_ex_bubble_s;
  assign pipe_stall_o   = pipe_stall_s;
  assign err_o          = (state_q == ST_ERROR);

`ifdef HAZARD_CTRL_PERF_EN
  logic lu_evt_s;
  logic ms_evt_s;

  assign lu_evt_s = (mode_s == MODE_ACTIVE) && hazard_s;
  assign ms_evt_s = (mode_s == MODE_MEMSTALL);

  sat_counter #(.W(CNT_W)) u_lu_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(lu_evt_s), .clr_i(1'b0), .cnt_o(load_use_cnt_o)
  );
  sat_counter #(.W(CNT_W)) u_mw_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(ms_evt_s), .clr_i(1'b0), .cnt_o(mem_wait_cnt_o)
  );
  sat_counter #(.W(CNT_W)) u_fl_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(if_id_flush_s), .clr_i(1'b0), .cnt_o(flush_cnt_o)
  );
`else
  assign load_use_cnt_o = {CNT_W{1'b0}};
  assign mem_wait_cnt_o = {CNT_W{1'b0}};
  assign flush_cnt_o    = {CNT_W{1'b0}};
`endif

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16: maximum data-memory wait cycles before error, legal range 1..255.
REQ-002 SHALL have port clk_i  in  1  sole clock, rising edge.
REQ-003 SHALL have port rst_i  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start_i  in  1  pipeline run enable.
REQ-005 SHALL have port id_rs1_addr_i  in  5  ID-stage source register 1 address.
REQ-006 SHALL have port id_rs2_addr_i  in  5  ID-stage source register 2 address.
REQ-007 SHALL have port ex_rd_addr_i  in  5  EX-stage destination register address.
REQ-008 SHALL have port ex_memread_i  in  1  EX-stage instruction is a load.
REQ-009 SHALL have port id_branch_taken_i  in  1  ID-stage branch resolved taken.
REQ-010 SHALL have port mem_req_i  in  1  MEM-stage load/store active.
REQ-011 SHALL have port mem_ack_i  in  1  data memory completes access this cycle.
REQ-012 SHALL have ports pc_write_o, if_id_write_o, if_id_flush_o, id_ex_bubble_o, pipe_stall_o  out  1 each: PC enable, IF/ID enable, IF/ID clear, zero ID control signals, freeze EX/MEM and MEM/WB.
REQ-013 SHALL have port err_o  out  1  sticky memory-timeout error.
REQ-014 SHALL have ports load_use_cnt_o, mem_wait_cnt_o, flush_cnt_o  out  16 each: event counters.

Function
REQ-015 SHALL implement states IDLE, RUN, MEM_WAIT, ERROR.
REQ-016 IDLE SHALL drive pc_write_o=0, if_id_write_o=0, id_ex_bubble_o=1, pipe_stall_o=1, if_id_flush_o=0; IDLE->RUN on next edge when start_i=1.
REQ-017 RUN SHALL ignore start_i.
REQ-018 Load-use hazard SHALL be ex_memread_i=1 and ex_rd_addr_i!=0 and ex_rd_addr_i equal to id_rs1_addr_i or id_rs2_addr_i.
REQ-019 In RUN with load-use hazard and no memory stall: pc_write_o=0, if_id_write_o=0, id_ex_bubble_o=1, pipe_stall_o=0, if_id_flush_o=0, combinationally in the same cycle.
REQ-020 In RUN with id_branch_taken_i=1 and no hazard and no memory stall: if_id_flush_o=1, pc_write_o=1; load-use hazard SHALL take priority and suppress flush.
REQ-021 In RUN with mem_req_i=1 and mem_ack_i=1: no memory stall, single-cycle access.
REQ-022 In RUN with mem_req_i=1 and mem_ack_i=0: pc_write_o=0, if_id_write_o=0, pipe_stall_o=1, id_ex_bubble_o=0, if_id_flush_o=0 this cycle; next state MEM_WAIT; memory stall overrides load-use and branch.
REQ-023 MEM_WAIT SHALL hold REQ-022 outputs while mem_ack_i=0 and increment an 8-bit wait counter each cycle.
REQ-024 MEM_WAIT with mem_ack_i=1 SHALL release stalls in that same cycle (RUN rules apply) and return to RUN, clearing the wait counter.
REQ-025 MEM_WAIT SHALL go to ERROR when the wait counter reaches MEM_TIMEOUT with mem_ack_i=0.
REQ-026 ERROR SHALL drive IDLE outputs plus err_o=1 and remain until reset.
REQ-027 Counters SHALL increment by 1 per cycle of: load-use stall, memory-stall cycle, and asserted if_id_flush_o respectively, saturating at 16'hFFFF.

Reset
REQ-028 rst_i=1 SHALL asynchronously force state IDLE, wait counter 0, err_o=0, all event counters 0, regardless of state mid-operation.
REQ-029 Outputs during reset SHALL equal IDLE outputs.

Configuration
REQ-030 With macro HAZARD_CTRL_PERF_EN defined, event counters SHALL be implemented per REQ-027.
REQ-031 Without HAZARD_CTRL_PERF_EN, counter ports SHALL remain present and be tied to 0, with no counter flops.

Structure
REQ-032 State encoding, counter width (16) and wait-counter width (8) SHALL live in shared package hazard_ctrl_pkg.
REQ-033 Event counters SHALL use one sub-module sat_counter (enable, clear, saturating output).

Verification
REQ-034 Reset, start_i=1 one cycle -> state RUN next edge, pc_write_o=1, id_ex_bubble_o=0.
REQ-035 RUN, ex_memread_i=1, ex_rd_addr_i=5, id_rs2_addr_i=5 -> pc_write_o=0, id_ex_bubble_o=1, load_use_cnt_o=1 next cycle; same with ex_rd_addr_i=0 -> no stall.
REQ-036 RUN, load hazard and id_branch_taken_i=1 together -> if_id_flush_o=0, flush_cnt_o unchanged.
REQ-037 mem_req_i=1, mem_ack_i low 3 cycles then high -> pipe_stall_o=1 for 3 cycles, released on ack cycle, mem_wait_cnt_o=3.
REQ-038 MEM_TIMEOUT=4, mem_ack_i held 0 -> ERROR, err_o=1; rst_i pulse mid-MEM_WAIT -> IDLE, err_o=0, counters 0 immediately.
